// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Handshaked pipeline stage register with a 2-entry skid buffer. It carries
//   an arbitrary payload between two CPU stages at full throughput. in_ready
//   comes straight from a flop, so out_ready never reaches it combinationally.
//   A synchronous flush kills every held entry, and out_data shows BUBBLE
//   whenever no entry is valid.
//
// Parameters:
//   DATA_W  payload width in bits
//   BUBBLE  value shown on out_data when empty; loaded on reset and flush
//   CNT_W   width of the statistics counters
//
// Ports:
//   clk        rising-edge clock
//   resetl     synchronous, active-low reset (overrides flush and handshakes)
//   flush      synchronous kill of all held entries
//   in_valid   upstream offers in_data
//   in_data    upstream payload
//   in_ready   stage can accept this cycle (registered)
//   out_valid  out_data holds a live payload
//   out_data   downstream payload (main register)
//   out_ready  downstream consumes this cycle
//   occupancy  number of held entries, 0..2
//   stall_cnt  cycles with out_valid & !out_ready (saturating)
//   flush_cnt  cycles with flush asserted outside reset (saturating)
//
// Build option:
//   PIPE_STAGE_STATS_EN  when defined, stall_cnt/flush_cnt are live saturating
//                        counters. When undefined they are tied to 0 and no
//                        counter flops exist.

module pipe_stage_skid #(
  parameter int                DATA_W = 96,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        occ_q, occ_d;
  logic              accept, pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A same-cycle accept is dropped; a same-cycle pop has already been
      // taken by the downstream, so nothing is left to re-present.
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (accept && pop) begin
            main_d  = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain into main can happen.
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end

    // The handshake outputs are derived from the next state and then
    // registered, so they change together with the state.
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
    case (state_d)
      ST_ONE:  occ_d = 2'd1;
      ST_FULL: occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetl) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters stop at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetl) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
